// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan controller:
// segment patterns (bit 7 = a ... bit 1 = g, bit 0 = dp) and the scan state enum.
package seg_scan_pkg;

    localparam logic [7:0] SEG_ZERO = 8'hFC;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    // Entry k holds the pattern for decimal digit k
    localparam logic [9:0][7:0] SEG_DIGIT_TBL = {
        8'hE6, 8'hFE, 8'hE0, 8'hBE, 8'hB6,
        8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [7:0] seg_digit(input logic [3:0] val);
        logic [7:0] pat;
        case (val)
            4'd0:    pat = SEG_DIGIT_TBL[0];
            4'd1:    pat = SEG_DIGIT_TBL[1];
            4'd2:    pat = SEG_DIGIT_TBL[2];
            4'd3:    pat = SEG_DIGIT_TBL[3];
            4'd4:    pat = SEG_DIGIT_TBL[4];
            4'd5:    pat = SEG_DIGIT_TBL[5];
            4'd6:    pat = SEG_DIGIT_TBL[6];
            4'd7:    pat = SEG_DIGIT_TBL[7];
            4'd8:    pat = SEG_DIGIT_TBL[8];
            4'd9:    pat = SEG_DIGIT_TBL[9];
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double-buffered updates.
// Optional macro SEG_INVERT_EN inverts seg_out and dig_en for common-anode/PNP boards.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int DWELL_CYC  = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_ONE    = IW'(1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

`ifdef SEG_INVERT_EN
    localparam logic [7:0]            SEG_POL = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = '1;
`else
    localparam logic [7:0]            SEG_POL = 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = '0;
`endif

    scan_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [8*NUM_DIGITS-1:0]   active_q, active_d;
    logic [8*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic                      pend_full_q, pend_full_d;
    logic [7:0]                seg_out_q, seg_nx_s;
    logic [NUM_DIGITS-1:0]     dig_en_q, dig_nx_s;
    logic                      frame_done_q;
    logic                      boundary_s;
    logic                      accept_s;

    // Scan FSM: blank gap, then dwell on the current digit; wrap marks the frame boundary
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        idx_d      = idx_q;
        boundary_s = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    state_d = BLANK;
                end
            end
            DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = '0;
                        boundary_s = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Double buffer: a pending update is promoted only at a frame boundary
    always_comb begin
        accept_s    = upd_valid && !pend_full_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (boundary_s && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end else if (accept_s) begin
            pend_d      = seg_in;
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // Output values for the upcoming cycle, taken from the next state so the flops line up with it
    always_comb begin
        seg_nx_s = SEG_OFF;
        dig_nx_s = '0;
        if (state_d == DRIVE) begin
            seg_nx_s = active_q[{idx_d, 3'b000} +: 8];
            dig_nx_s = DIG_ONE << idx_d;
        end else begin
            seg_nx_s = SEG_OFF;
            dig_nx_s = '0;
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= {NUM_DIGITS{SEG_ZERO}};
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            seg_out_q    <= SEG_OFF ^ SEG_POL;
            dig_en_q     <= DIG_POL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            seg_out_q    <= seg_nx_s ^ SEG_POL;
            dig_en_q     <= dig_nx_s ^ DIG_POL;
            frame_done_q <= boundary_s;
        end
    end

    assign upd_ready  = !pend_full_q;
    assign seg_out    = seg_out_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (3 digits, dwell 4, blank 2 -> 18-cycle frame).
module tb_seg_scan_ctrl;

    localparam int ND    = 3;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = ND * SLOT;

`ifdef SEG_INVERT_EN
    localparam logic [7:0]    SPOL = 8'hFF;
    localparam logic [ND-1:0] DPOL = 3'b111;
`else
    localparam logic [7:0]    SPOL = 8'h00;
    localparam logic [ND-1:0] DPOL = 3'b000;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [8*ND-1:0] seg_in = '0;
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [7:0]      seg_out;
    logic [ND-1:0]   dig_en;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    // Model: cycles since the last reset edge, the displayed patterns and the one-deep pending slot
    int              t = 0;
    logic [7:0]      m_active [ND];
    logic [8*ND-1:0] m_pend = '0;
    logic            m_pend_full = 1'b0;
    logic [ND-1:0]   prev_en = '0;
    logic [7:0]      prev_seg = 8'h00;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    // Expected outputs follow from the position inside the frame alone
    task automatic compare();
        int p, d, w;
        logic [ND-1:0] e_en;
        logic [7:0]    e_seg;
        logic [ND-1:0] en_a;
        logic [7:0]    seg_a;
        p = t % FRAME;
        d = p / SLOT;
        w = p % SLOT;
        if (w >= BL) begin
            e_en  = ND'(1) << d;
            e_seg = m_active[d];
        end else begin
            e_en  = '0;
            e_seg = 8'h00;
        end
        en_a  = dig_en ^ DPOL;
        seg_a = seg_out ^ SPOL;
        chk("dig_en", {29'd0, en_a}, {29'd0, e_en});
        chk("seg_out", {24'd0, seg_a}, {24'd0, e_seg});
        chk("frame_done", {31'd0, frame_done}, {31'd0, (t > 0 && p == 0)});
        chk("upd_ready", {31'd0, upd_ready}, {31'd0, !m_pend_full});
        chk("onehot0", {31'd0, $onehot0(en_a)}, 32'd1);
        if (prev_en != '0 && en_a == prev_en)
            chk("seg_hold", {24'd0, seg_a}, {24'd0, prev_seg});
        prev_en  = en_a;
        prev_seg = seg_a;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            t = 0;
            for (int i = 0; i < ND; i++) m_active[i] = 8'hFC;
            m_pend_full = 1'b0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_pend_full) begin
                for (int i = 0; i < ND; i++) m_active[i] = m_pend[8*i +: 8];
                m_pend_full = 1'b0;
            end else if (upd_valid && !m_pend_full) begin
                m_pend      = seg_in;
                m_pend_full = 1'b1;
            end
            t++;
        end
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic lit(input string name, input logic [7:0] e_seg, input logic [ND-1:0] e_en);
        chk({name, "_seg"}, {24'd0, seg_out ^ SPOL}, {24'd0, e_seg});
        chk({name, "_en"}, {29'd0, dig_en ^ DPOL}, {29'd0, e_en});
    endtask

    initial begin
        int fd_cnt;
        for (int i = 0; i < ND; i++) m_active[i] = 8'hFC;

        // Reset and first frame
        rst = 1'b0;
        run(3);
`ifdef SEG_INVERT_EN
        chk("rst_raw_seg", {24'd0, seg_out}, 32'h0000_00FF);
        chk("rst_raw_en", {29'd0, dig_en}, 32'd7);
`else
        chk("rst_raw_seg", {24'd0, seg_out}, 32'h0000_0000);
        chk("rst_raw_en", {29'd0, dig_en}, 32'd0);
`endif
        chk("rst_ready", {31'd0, upd_ready}, 32'd1);
        rst = 1'b1;
        run(2);
        lit("t2", 8'hFC, 3'b001);
`ifdef SEG_INVERT_EN
        chk("inv_raw_seg", {24'd0, seg_out}, 32'h0000_0003);
        chk("inv_raw_en", {29'd0, dig_en}, 32'd6);
`endif
        run(6);
        lit("t8", 8'hFC, 3'b010);
        run(10);
        chk("t18_fd", {31'd0, frame_done}, 32'd1);

        // Single update mid-frame
        run(3);
        seg_in = {8'h60, 8'hDA, 8'hF2};
        upd_valid = 1'b1;
        run(1);
        upd_valid = 1'b0;
        chk("upd_stall", {31'd0, upd_ready}, 32'd0);
        run(14);
        chk("t36_fd", {31'd0, frame_done}, 32'd1);
        run(1);
        chk("t37_ready", {31'd0, upd_ready}, 32'd1);
        run(1);
        lit("t38", 8'hF2, 3'b001);
        run(6);
        lit("t44", 8'hDA, 3'b010);
        run(6);
        lit("t50", 8'h60, 3'b100);

        // Back-to-back updates A then B with valid held
        seg_in = {8'hBE, 8'hB6, 8'h66};
        upd_valid = 1'b1;
        run(1);
        chk("a_taken", {31'd0, upd_ready}, 32'd0);
        seg_in = {8'hE6, 8'hFE, 8'hE0};
        run(4);
        upd_valid = 1'b0;
        chk("b_taken", {31'd0, upd_ready}, 32'd0);
        run(1);
        lit("t56_a", 8'h66, 3'b001);
        run(6);
        lit("t62_a", 8'hB6, 3'b010);
        run(12);
        lit("t74_b", 8'hE0, 3'b001);

        // Reset during digit-1 drive with an update pending
        seg_in = {8'h11, 8'h22, 8'h33};
        upd_valid = 1'b1;
        run(1);
        upd_valid = 1'b0;
        run(6);
        lit("t81", 8'hFE, 3'b010);
        rst = 1'b0;
        run(1);
        lit("mid_rst", 8'h00, 3'b000);
        chk("mid_rst_ready", {31'd0, upd_ready}, 32'd1);
        run(1);
        rst = 1'b1;
        run(2);
        lit("r2", 8'hFC, 3'b001);
        run(18);
        lit("r20", 8'hFC, 3'b001);

        // Free run: frame_done every 18 cycles (t=21..120 holds pulses at 36,54,72,90,108)
        fd_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (frame_done) fd_cnt++;
        end
        chk("fd_count", fd_cnt, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
